// File: rtl/tiny32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the tiny32 bus: a byte FIFO feeds a
// start/data/stop serialiser, and writes into a full FIFO are held off through ready.
module tiny32_uart_tx #(
    parameter int          FIFO_DEPTH_BITS = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd103
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        sel,
    input  logic [1:0]  address,
    input  logic        nrd,
    input  logic [3:0]  nwr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        irq,
    output logic        tx
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS:0]   CNT_FULL = (FIFO_DEPTH_BITS+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = FIFO_DEPTH_BITS'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                       done_reg;
    logic [15:0]                divisor_reg;
    logic                       enable_reg;
    logic                       irq_en_reg;
    logic                       stall_reg;
    logic [7:0]                 stall_byte_reg;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]   count_reg;

    state_t                     state_reg;
    logic [15:0]                baud_reg;
    logic [15:0]                frame_div_reg;
    logic [2:0]                 bit_idx_reg;
    logic [7:0]                 shift_reg;

    logic                       strobe;
    logic                       accept;
    logic                       wr_acc;
    logic                       rd_acc;
    logic                       full;
    logic                       empty;
    logic                       busy;
    logic                       data_wr;
    logic                       clr;
    logic                       pop;
    logic                       stall_push;
    logic                       new_push;
    logic                       stall_start;
    logic                       push;
    logic [7:0]                 push_byte;
    logic [FIFO_DEPTH_BITS-1:0] push_addr;
    logic [31:0]                rd_data;
    logic                       unused_data;

    assign unused_data = ^data_in[31:16];

    assign strobe = sel & (~nrd | (nwr != 4'hF));
    assign accept = strobe & ~done_reg;
    assign wr_acc = accept & (nwr != 4'hF);
    assign rd_acc = accept & ~nrd;

    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);
    assign busy  = (state_reg != IDLE);

    assign data_wr = wr_acc & (address == 2'd0) & ~nwr[0];
    assign clr     = wr_acc & (address == 2'd3) & ~nwr[0] & data_in[1];
    assign pop     = (state_reg == IDLE) & enable_reg & ~empty;

    // A stalled byte survives a clear: the clear makes room for it.
    assign stall_push  = stall_reg & (~full | clr);
    assign new_push    = data_wr & ~full & ~stall_reg & ~clr;
    assign stall_start = data_wr & full & ~stall_reg & ~clr;
    assign push        = stall_push | new_push;
    assign push_byte   = stall_reg ? stall_byte_reg : data_in[7:0];
    assign push_addr   = clr ? '0 : wr_ptr_reg;

    always_comb begin
        rd_data = '0;
        case (address)
            2'd1: begin
                rd_data[0] = full;
                rd_data[1] = empty;
                rd_data[2] = busy;
                rd_data[8 +: FIFO_DEPTH_BITS+1] = count_reg;
            end
            2'd2: rd_data[15:0] = divisor_reg;
            2'd3: begin
                rd_data[0] = enable_reg;
                rd_data[2] = irq_en_reg;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            done_reg       <= 1'b0;
            data_out       <= '0;
            ready          <= 1'b1;
            irq            <= 1'b0;
            divisor_reg    <= DEFAULT_DIVISOR;
            enable_reg     <= 1'b0;
            irq_en_reg     <= 1'b0;
            stall_reg      <= 1'b0;
            stall_byte_reg <= '0;
        end else begin
            done_reg <= strobe;
            irq      <= irq_en_reg & empty & (state_reg == IDLE);
            if (rd_acc)
                data_out <= rd_data;
            if (wr_acc && address == 2'd2) begin
                if (!nwr[0]) divisor_reg[7:0]  <= data_in[7:0];
                if (!nwr[1]) divisor_reg[15:8] <= data_in[15:8];
            end
            if (wr_acc && address == 2'd3 && !nwr[0]) begin
                enable_reg <= data_in[0];
                irq_en_reg <= data_in[2];
            end
            if (stall_start) begin
                stall_reg      <= 1'b1;
                stall_byte_reg <= data_in[7:0];
                ready          <= 1'b0;
            end else if (stall_push) begin
                stall_reg <= 1'b0;
                ready     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[push_addr] <= push_byte;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= push ? PTR_ONE : '0;
            count_reg  <= push ? CNT_ONE : '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push && !pop)
                count_reg <= count_reg + CNT_ONE;
            else if (pop && !push)
                count_reg <= count_reg - CNT_ONE;
        end
    end

    // The divisor is captured per frame so mid-frame writes only affect later frames.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg     <= IDLE;
            tx            <= 1'b1;
            baud_reg      <= '0;
            frame_div_reg <= DEFAULT_DIVISOR;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift_reg     <= mem[rd_ptr_reg];
                        baud_reg      <= divisor_reg;
                        frame_div_reg <= divisor_reg;
                        tx            <= 1'b0;
                        state_reg     <= START;
                    end
                end
                START: begin
                    if (baud_reg == '0) begin
                        baud_reg    <= frame_div_reg;
                        bit_idx_reg <= '0;
                        tx          <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_reg == '0) begin
                        baud_reg <= frame_div_reg;
                        if (bit_idx_reg == 3'd7) begin
                            tx        <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx          <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_reg == '0)
                        state_reg <= IDLE;
                    else
                        baud_reg <= baud_reg - 16'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny32_uart_tx.sv
// Bench for tiny32_uart_tx: register vectors, hand-timed frame sequences and random
// bursts checked against a line-level receiver and a byte-queue model.
module tb_tiny32_uart_tx;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        nrd = 1'b1;
    logic [3:0]  nwr = 4'hF;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ready;
    logic        irq;
    logic        tx;

    tiny32_uart_tx #(.FIFO_DEPTH_BITS(4), .DEFAULT_DIVISOR(16'd103)) dut (
        .clk(clk), .nreset(nreset), .sel(sel), .address(address), .nrd(nrd),
        .nwr(nwr), .data_in(data_in), .data_out(data_out), .ready(ready),
        .irq(irq), .tx(tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         mon_p = 4;
    logic       mon_active = 1'b0;
    int         mon_t, mon_fp, mon_k;
    logic [7:0] mon_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line receiver: samples mid-bit with the bit period in force when the frame started.
    always @(negedge clk) begin
        cyc++;
        if (!nreset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                mon_fp = mon_p;
                mon_byte = '0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t % mon_fp == mon_fp / 2) begin
                mon_k = mon_t / mon_fp;
                if (mon_k == 0) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_q.push_back(mon_byte);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] lanes,
                       input logic rd_en, output logic [31:0] rdata, output int waits);
        sel = 1'b1; address = a; data_in = d; nwr = lanes; nrd = ~rd_en;
        @(posedge clk); #1;
        rdata = data_out;
        waits = 0;
        if (lanes != 4'hF)
            while (ready !== 1'b1 && waits < 50) begin
                @(posedge clk); #1;
                waits++;
            end
        sel = 1'b0; nwr = 4'hF; nrd = 1'b1;
        @(posedge clk); #1;
        $display("bus addr=%0d lanes=%b rd=%0d wdata=%h rdata=%h waits=%0d",
                 a, lanes, rd_en, d, rdata, waits);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        int w;
        bus(a, d, 4'hE, 1'b0, r, w);
        check("wr_ready", w, 0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        int w;
        bus(a, 32'd0, 4'hF, 1'b1, r, w);
    endtask

    task automatic wait_tx_fall();
        int n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_fall_timeout", {31'd0, n < 400}, 32'd1);
    endtask

    task automatic wait_rx(input int n, input int limit);
        int c = 0;
        while (rx_q.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic clear_queues();
        rx_q.delete();
        exp_q.delete();
        start_q.delete();
    endtask

    task automatic check_rx_bytes(input int spacing);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rx_byte", rx_q[i], exp_q[i]);
        for (int i = 1; i < start_q.size(); i++)
            check("start_spacing", start_q[i] - start_q[i-1], spacing);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [3:0]  lanes;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          w;
        logic [7:0]  a5;
        logic [7:0]  b;
        int          e;
        int          d;
        int          n;

        // reset state
        #23 nreset = 1'b1;
        @(posedge clk); #1;
        check("rst_data_out", data_out, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(2'd1, r); check("rst_status", r, 32'h2);
        rd(2'd2, r); check("rst_divisor", r, 32'd103);

        // register vectors: a read in the same access returns the pre-write value
        vecs[0]  = '{2'd2, 4'hC, 1'b0, 32'hFFFF1234, 32'h1234};
        vecs[1]  = '{2'd2, 4'hD, 1'b0, 32'h0000AB00, 32'hAB34};
        vecs[2]  = '{2'd2, 4'hE, 1'b0, 32'h000000CD, 32'hABCD};
        vecs[3]  = '{2'd2, 4'hB, 1'b0, 32'hFFFFFFFF, 32'hABCD};
        vecs[4]  = '{2'd2, 4'hC, 1'b1, 32'h00000007, 32'hABCD};
        vecs[5]  = '{2'd2, 4'hF, 1'b1, 32'h00000000, 32'h0007};
        vecs[6]  = '{2'd3, 4'hE, 1'b0, 32'hFFFFFFFF, 32'h0005};
        vecs[7]  = '{2'd3, 4'hE, 1'b1, 32'h00000000, 32'h0005};
        vecs[8]  = '{2'd3, 4'hF, 1'b1, 32'h00000000, 32'h0000};
        vecs[9]  = '{2'd1, 4'h0, 1'b0, 32'hFFFFFFFF, 32'h0002};
        vecs[10] = '{2'd0, 4'hF, 1'b1, 32'h00000000, 32'h0000};
        vecs[11] = '{2'd2, 4'hC, 1'b0, 32'h00000003, 32'h0003};
        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].lanes, vecs[i].rd, r, w);
            if (!vecs[i].rd)
                rd(vecs[i].addr, r);
            check($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // FIFO clear with enable off
        clear_queues();
        wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33);
        rd(2'd1, r); check("status_three", r, 32'h300);
        wr(2'd3, 32'h2);
        rd(2'd3, r); check("ctrl_clear_reads0", r, 32'h0);
        rd(2'd1, r); check("status_cleared", r, 32'h2);

        // exact A5 frame at 4 clks per bit
        wr(2'd3, 32'h1);
        mon_p = 4;
        a5 = 8'hA5;
        clear_queues();
        fork
            bus(2'd0, 32'hA5, 4'hE, 1'b0, r, w);
            begin
                wait_tx_fall();
                for (int k = 0; k < 42; k++) begin
                    if (k > 0) @(negedge clk);
                    if (k / 4 == 0) e = 0;
                    else if (k / 4 <= 8) e = a5[k/4 - 1];
                    else e = 1;
                    check($sformatf("frame_a5_k%0d", k), {31'd0, tx}, e);
                end
            end
        join
        check("a5_ready", w, 0);
        rd(2'd1, r); check("a5_idle_status", r, 32'h2);
        check("a5_rx_count", rx_q.size(), 1);
        exp_q.push_back(8'hA5);
        check_rx_bytes(41);

        // 17 writes into a 16-deep FIFO with the transmitter disabled
        clear_queues();
        wr(2'd3, 32'h0);
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, 32'h40 + i);
            exp_q.push_back(8'(32'h40 + i));
        end
        sel = 1'b1; address = 2'd0; nwr = 4'hE; data_in = 32'h77;
        @(posedge clk); #1;
        check("stall_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("stall_hold", {31'd0, ready}, 32'd0);
        sel = 1'b0; nwr = 4'hF;
        @(posedge clk); #1;
        rd(2'd1, r); check("stall_status_full", r, 32'h1001);
        check("stall_still", {31'd0, ready}, 32'd0);
        bus(2'd3, 32'h1, 4'hE, 1'b0, r, w);
        check("unstall_within_2", {31'd0, (w >= 1 && w <= 2)}, 32'd1);
        exp_q.push_back(8'h77);
        rd(2'd1, r); check("unstall_status", r, 32'h1005);
        wait_rx(17, 17 * 41 + 100);
        check_rx_bytes(41);
        repeat (5) @(posedge clk);
        #1 rd(2'd1, r); check("drained_status", r, 32'h2);

        // back-to-back pair, then a mid-frame divisor change
        clear_queues();
        wr(2'd0, 32'h3C); wr(2'd0, 32'hC3);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        wait_rx(2, 200);
        check("pair_starts", start_q.size(), 2);
        check_rx_bytes(41);
        repeat (6) @(posedge clk);
        clear_queues();
        wr(2'd0, 32'h5A);
        repeat (8) @(posedge clk);
        #1 wr(2'd2, 32'h7);
        rd(2'd1, r); check("midframe_status", r, 32'h6);
        exp_q.push_back(8'h5A);
        wait_rx(1, 100);
        check_rx_bytes(41);
        repeat (6) @(posedge clk);
        clear_queues();
        mon_p = 8;
        wr(2'd0, 32'h96);
        exp_q.push_back(8'h96);
        wait_rx(1, 200);
        check_rx_bytes(81);
        repeat (10) @(posedge clk);
        #1 wr(2'd2, 32'h3);
        mon_p = 4;

        // randomized bursts against the byte-queue model
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(1, 5);
            n = $urandom_range(1, 16);
            wr(2'd3, 32'h0);
            wr(2'd2, d);
            mon_p = d + 1;
            clear_queues();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                wr(2'd0, {24'd0, b});
                exp_q.push_back(b);
            end
            rd(2'd1, r);
            check("rand_status", r, (n << 8) | (n == 16 ? 1 : 0));
            wr(2'd3, 32'h1);
            wait_rx(n, n * (10 * (d + 1) + 1) + 60);
            check_rx_bytes(10 * (d + 1) + 1);
            repeat (d + 4) @(posedge clk);
            #1 rd(2'd1, r); check("rand_idle_status", r, 32'h2);
        end
        wr(2'd2, 32'h3);
        mon_p = 4;

        // transmit-done interrupt
        clear_queues();
        wr(2'd3, 32'h5);
        repeat (2) @(posedge clk);
        #1 check("irq_idle", {31'd0, irq}, 32'd1);
        fork
            bus(2'd0, 32'hF0, 4'hE, 1'b0, r, w);
            begin
                wait_tx_fall();
                check("irq_k0", {31'd0, irq}, 32'd0);
                repeat (20) @(negedge clk);
                check("irq_k20", {31'd0, irq}, 32'd0);
                repeat (20) @(negedge clk);
                check("irq_k40", {31'd0, irq}, 32'd0);
                @(negedge clk);
                check("irq_k41", {31'd0, irq}, 32'd1);
            end
        join
        exp_q.push_back(8'hF0);
        check_rx_bytes(41);

        // asynchronous reset in the middle of a data bit
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h00); wr(2'd0, 32'h22); wr(2'd0, 32'h33);
        wait_tx_fall();
        repeat (10) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        #14 nreset = 1'b1;
        clear_queues();
        @(posedge clk); #1;
        repeat (80) @(posedge clk);
        #1;
        check("no_residual_starts", start_q.size(), 0);
        check("no_residual_bytes", rx_q.size(), 0);
        check("post_rst_tx", {31'd0, tx}, 32'd1);
        rd(2'd1, r); check("post_rst_status", r, 32'h2);
        rd(2'd2, r); check("post_rst_divisor", r, 32'd103);
        rd(2'd3, r); check("post_rst_ctrl", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
